// File: rtl/cache_pkg.sv
// Shared definitions for the cache request arbiter: FSM state encoding and
// cache mode values.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_WRITE = 1'b1;
  localparam logic MODE_READ  = 1'b0;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_select #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any_req
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = IDX_W'((int'(ptr) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one cache request port between NUM_REQ
// requesters; holds the granted request on the cache inputs until the next grant.
module cache_arbiter
  import cache_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_mode,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      err,
  output logic                      busy,
  output logic [DATA_W-1:0]         cache_data,
  output logic [ADDR_W-1:0]         cache_address,
  output logic                      cache_mode,
  input  logic                      cache_response,
  input  logic [DATA_W-1:0]         cache_out,
  output state_t                    dbg_state
);

  localparam int         IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  // Handshake: a requester holds req high with stable fields until it sees
  // its one-cycle ack; it must drop req on the following cycle or be re-served.

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] sel_grant, grant_q;
  logic [IDX_W-1:0]   sel_idx, winner_q, ptr_q;
  logic               sel_any, grant_ok, timed_out_q;
  logic [7:0]         wait_cnt_q;
  logic [DATA_W-1:0]  rdata_q;

  rr_select #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_select (
    .req     (req),
    .ptr     (ptr_q),
    .grant   (sel_grant),
    .idx     (sel_idx),
    .any_req (sel_any)
  );

  // A miss left outstanding across reset must drain before the next grant.
  assign grant_ok = (state_q == IDLE) && sel_any && !cache_response;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_ok) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (!cache_response || wait_cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cache_mode    <= MODE_READ;
      cache_address <= '0;
      cache_data    <= '0;
      winner_q      <= '0;
      grant_q       <= '0;
      ptr_q         <= '0;
      wait_cnt_q    <= '0;
      timed_out_q   <= 1'b0;
      rdata_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (grant_ok) begin
          cache_mode    <= req_mode[sel_idx];
          cache_address <= req_addr[sel_idx*ADDR_W +: ADDR_W];
          cache_data    <= req_data[sel_idx*DATA_W +: DATA_W];
          winner_q      <= sel_idx;
          grant_q       <= sel_grant;
        end
        ISSUE: begin
          wait_cnt_q  <= '0;
          timed_out_q <= 1'b0;
        end
        WAIT: begin
          if (!cache_response) begin
            if (cache_mode == MODE_READ) rdata_q <= cache_out;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
            if (wait_cnt_q == CNT_LAST) timed_out_q <= 1'b1;
          end
        end
        DONE: ptr_q <= (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign ack       = (state_q == DONE) ? grant_q : '0;
  assign err       = (state_q == DONE) && timed_out_q;
  assign busy      = (state_q != IDLE);
  assign rdata     = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: behavioural cache model, transaction-level
// round-robin reference with expected queue, and a decoupled ack monitor.
module tb_cache_arbiter;
  import cache_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int EW = 1 + N + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_mode = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata;
  logic            err, busy;
  logic [DW-1:0]   cache_data;
  logic [AW-1:0]   cache_address;
  logic            cache_mode;
  logic            cache_response = 1'b0;
  logic [DW-1:0]   cache_out = '0;
  state_t          dbg_state;

  cache_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(255)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_mode       (req_mode),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .ack            (ack),
    .rdata          (rdata),
    .err            (err),
    .busy           (busy),
    .cache_data     (cache_data),
    .cache_address  (cache_address),
    .cache_mode     (cache_mode),
    .cache_response (cache_response),
    .cache_out      (cache_out),
    .dbg_state      (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0FFEE00;
  endfunction

  // ---------------- behavioural cache ----------------
  // Triggers on a change of its inputs seen at a falling edge; a miss keeps
  // response high for the chosen number of arbiter WAIT cycles.
  logic [DW-1:0]   mem [logic [AW-1:0]];
  int              next_lat = 0;
  bit              rand_lat = 1'b0;
  int              pend = 0;
  int              cm_lat;
  logic [AW+DW:0]  last_in = '0;
  logic            p_mode = 1'b0;
  logic [AW-1:0]   p_addr = '0;

  always @(negedge clk) begin
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        cache_response = 1'b0;
        if (!p_mode) cache_out = mem.exists(p_addr) ? mem[p_addr] : dflt(p_addr);
      end
    end else if ({cache_mode, cache_address, cache_data} !== last_in) begin
      last_in = {cache_mode, cache_address, cache_data};
      p_mode  = cache_mode;
      p_addr  = cache_address;
      if (cache_mode) mem[cache_address] = cache_data;
      cm_lat = rand_lat ? int'($urandom_range(0, 4)) : next_lat;
      if (cm_lat == 0) begin
        if (!cache_mode) cache_out = mem.exists(cache_address) ? mem[cache_address] : dflt(cache_address);
      end else begin
        cache_response = 1'b1;
        pend = cm_lat + 1;
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] ref_last = '0;
  int            ref_ptr = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int off = 0; off < N; off++)
      if (m[(p + off) % N]) return (p + off) % N;
    return -1;
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem[a] = d;
    ref_mem[a] = d;
  endtask

  task automatic expect_txn(input int i, input logic mode, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input bit to);
    logic [N-1:0] oh;
    oh = N'(1) << i;
    if (!to) begin
      if (mode) ref_mem[a] = d;
      else ref_last = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    end
    exp_q.push_back({to, oh, ref_last});
    ref_ptr = (i + 1) % N;
  endtask

  always @(negedge clk) begin
    if (ack !== '0) begin
      if (exp_q.size() == 0) check_eq("unexpected_ack", 64'(ack), 64'd0);
      else begin
        mon_e = exp_q.pop_front();
        check_eq("ack_grant", 64'(ack), 64'(mon_e[EW-2 -: N]));
        check_eq("ack_err", 64'(err), 64'(mon_e[EW-1]));
        check_eq("ack_rdata", 64'(rdata), 64'(mon_e[DW-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic mode, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_mode[i] = mode;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
    req[i] = 1'b1;
  endtask

  task automatic start_req(input int i, input logic mode, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int lat, input bit to);
    next_lat = lat;
    expect_txn(i, mode, a, d, to);
    @(negedge clk);
    set_req(i, mode, a, d);
  endtask

  task automatic wait_ack(input string name, input int i, input int exp_cyc,
                          input bit chk_hold, input logic [AW+DW:0] hold_val);
    int cyc = 0;
    int bad = 0;
    bit got = 1'b0;
    for (int k = 0; k < 600 && !got; k++) begin
      @(negedge clk);
      if (busy) cyc++;
      if (chk_hold && busy && ({cache_mode, cache_address, cache_data} !== hold_val)) bad++;
      if (ack[i]) begin
        got = 1'b1;
        req[i] = 1'b0;
      end
    end
    check_eq({name, "_ack_seen"}, 64'(got), 64'd1);
    check_eq({name, "_latency"}, 64'(cyc), 64'(exp_cyc));
    if (chk_hold) check_eq({name, "_hold"}, 64'(bad), 64'd0);
  endtask

  task automatic stall_check(input string name);
    int early = 0;
    for (int k = 0; k < 400 && cache_response; k++) begin
      @(negedge clk);
      #1;
      if (busy) early++;
    end
    check_eq({name, "_no_grant_while_miss"}, 64'(early), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  int            order[5];
  int            exp_order[5] = '{0, 1, 2, 3, 0};
  int            n_acks;
  logic [N-1:0]  mask, pending;
  logic          rb_mode [N];
  logic [AW-1:0] rb_addr [N];
  logic [DW-1:0] rb_data [N];
  int            w;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    #1;
    check_eq("reset_ctrl", 64'({ack, busy, err, cache_mode}), 64'd0);
    check_eq("reset_rdata", 64'(rdata), 64'd0);
    check_eq("reset_cache_data", 64'(cache_data), 64'd0);
    check_eq("reset_cache_addr", 64'(cache_address), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // all four requesting continuously from pointer 0
    for (int k = 0; k < 5; k++) begin
      w = pick(4'hF, ref_ptr);
      expect_txn(w, MODE_READ, 32'h100 + 32'(w * 4), '0, 1'b0);
    end
    next_lat = 0;
    @(negedge clk);
    for (int i = 0; i < N; i++) set_req(i, MODE_READ, 32'h100 + 32'(i * 4), '0);
    n_acks = 0;
    for (int k = 0; k < 100 && n_acks < 5; k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (ack[i]) begin
          order[n_acks] = i;
          n_acks++;
        end
      if (n_acks == 5) req = '0;
    end
    check_eq("rr_ack_count", 64'(n_acks), 64'd5);
    for (int k = 0; k < 5; k++) check_eq($sformatf("rr_order_%0d", k), 64'(order[k]), 64'(exp_order[k]));
    req = '0;

    // single read hit, then a 5-cycle miss
    preload(32'h10, 32'hDEADBEEF);
    preload(32'h14, 32'h12345678);
    start_req(0, MODE_READ, 32'h10, '0, 0, 1'b0);
    wait_ack("read_hit", 0, 3, 1'b0, '0);
    start_req(0, MODE_READ, 32'h14, '0, 5, 1'b0);
    wait_ack("read_miss", 0, 8, 1'b0, '0);

    // write: cache inputs held through DONE and afterwards in IDLE
    start_req(2, MODE_WRITE, 32'h40, 32'hA5A5A5A5, 2, 1'b0);
    wait_ack("write", 2, 5, 1'b1, {MODE_WRITE, 32'h40, 32'hA5A5A5A5});
    repeat (3) @(negedge clk);
    check_eq("write_idle_hold", 64'({cache_mode, cache_address}), 64'({MODE_WRITE, 32'h40}));
    check_eq("write_idle_data", 64'(cache_data), 64'h A5A5A5A5);

    // identical repeat: cache does not re-trigger, so the second is a hit
    start_req(3, MODE_READ, 32'h80, 32'h77, 5, 1'b0);
    wait_ack("repeat_first", 3, 8, 1'b0, '0);
    start_req(3, MODE_READ, 32'h80, 32'h77, 5, 1'b0);
    wait_ack("repeat_second", 3, 3, 1'b0, '0);

    // timeout with the miss still outstanding afterwards
    start_req(0, MODE_READ, 32'h200, '0, 300, 1'b1);
    wait_ack("timeout", 0, 257, 1'b0, '0);
    start_req(1, MODE_READ, 32'h204, '0, 0, 1'b0);
    stall_check("after_timeout");
    wait_ack("after_timeout", 1, 3, 1'b0, '0);

    // reset in the middle of WAIT abandons the transaction
    next_lat = 20;
    @(negedge clk);
    set_req(1, MODE_READ, 32'h300, '0);
    for (int k = 0; k < 20 && !busy; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_eq("pre_reset_in_wait", 64'(dbg_state), 64'(WAIT));
    #2 reset = 1'b1;
    #1;
    check_eq("midreset_ctrl", 64'({ack, busy, err, cache_mode}), 64'd0);
    check_eq("midreset_rdata", 64'(rdata), 64'd0);
    check_eq("midreset_cache", 64'({cache_address, cache_data}), 64'd0);
    ref_last = '0;
    ref_ptr = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    expect_txn(1, MODE_READ, 32'h300, '0, 1'b0);
    stall_check("after_reset");
    wait_ack("after_reset", 1, 3, 1'b0, '0);

    // randomized batches of simultaneous requests
    rand_lat = 1'b1;
    @(negedge clk);
    for (int b = 0; b < 30; b++) begin
      mask = N'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        rb_mode[i] = 1'($urandom_range(0, 1));
        rb_addr[i] = 32'h1000 | (32'($urandom_range(0, 7)) << 2);
        rb_data[i] = $urandom();
      end
      pending = mask;
      while (pending != '0) begin
        w = pick(pending, ref_ptr);
        expect_txn(w, rb_mode[w], rb_addr[w], rb_data[w], 1'b0);
        pending[w] = 1'b0;
      end
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (mask[i]) set_req(i, rb_mode[i], rb_addr[i], rb_data[i]);
      pending = mask;
      for (int k = 0; k < 300 && pending != '0; k++) begin
        @(negedge clk);
        for (int i = 0; i < N; i++)
          if (ack[i]) begin
            req[i] = 1'b0;
            pending[i] = 1'b0;
          end
      end
      check_eq($sformatf("batch_%0d_complete", b), 64'(pending), 64'd0);
      @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
Shares the single cache_f request port between NUM_REQ independent requesters using round-robin arbitration. Drives the cache's data/address/mode inputs from a registered, held-stable copy of the granted request. Waits for the cache's response to fall, then returns read data and a one-cycle ack to the winner. Sits between the requester-side ports and cache_f; it is the only driver of the cache inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, max cycles in WAIT before forced error completion (8-bit counter)

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester request; held high with fields stable until ack
req_mode  in  NUM_REQ  per-requester op: 1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  packed write data, same packing
ack  out  NUM_REQ  one-hot, one-cycle completion pulse to the served requester
rdata  out  DATA_W  read data, valid while ack is high; holds last value otherwise
err  out  1  high with ack when completion was forced by timeout
busy  out  1  high in any state other than IDLE
cache_data  out  DATA_W  to cache data
cache_address  out  ADDR_W  to cache address
cache_mode  out  1  to cache mode
cache_response  in  1  from cache response; 1 = miss outstanding
cache_out  in  DATA_W  from cache out

Behaviour:
- Reset: state IDLE; ack=0; err=0; busy=0; rdata=0; cache_data/address/mode=0; rr pointer=0; wait counter=0. Reset mid-transaction abandons it and issues no ack.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: grant only when any req is high and cache_response==0. The latter guards against a miss left outstanding across reset. Winner is the first asserted req at or after the pointer, wrapping modulo NUM_REQ. Register the winner's mode/addr/data onto the cache_* outputs, store the winner index, then go to ISSUE.
- ISSUE: exactly one cycle. The cache samples the new inputs on the falling edge inside this cycle. Clear the wait counter, then go to WAIT.
- WAIT: if cache_response==0, capture cache_out into rdata (reads only; writes leave rdata unchanged), then go to DONE. Otherwise increment the counter. When the counter reaches TIMEOUT, set err and go to DONE.
- DONE: ack[winner]=1 for this cycle only; err valid alongside. Pointer becomes winner+1, wrapping to 0. Next state IDLE.
- cache_* outputs hold their value from IDLE-grant through DONE and keep holding in IDLE until the next grant. They never glitch between grants.
- Latency from grant edge: cache hit or write gives ack on the 3rd rising edge after grant (IDLE to ISSUE to WAIT to DONE). A miss adds one cycle per cycle that response stays high.
- Requester protocol: req must drop on the cycle after ack is seen. A req still high in IDLE is treated as a new request.
- Repeated identical request: the cache does not re-trigger, so response stays 0 and ack follows with the held output. This is legal, and rdata equals the last value the cache produced for that address.
- Simultaneous requests: exactly one grant per transaction. No requester waits more than NUM_REQ-1 transactions.
- req changing while not granted has no effect until arbitration in IDLE.

Decomposition:
- Shared package cache_pkg: state encoding localparams (IDLE=0, ISSUE=1, WAIT=2, DONE=3); MODE_WRITE=1, MODE_READ=0.
- One sub-module rr_select(NUM_REQ): combinational round-robin pick from req vector and pointer, producing one-hot grant, index and any_req.
- The FSM, registers and counter stay in cache_arbiter.

Test Plan:
- Reset asserted mid-WAIT with req[1]=1 -> ack stays 0, busy=0 and all outputs 0 asynchronously. After release, no grant occurs while cache_response=1.
- Single read hit: req[0], addr=0x10, cache_out=0xDEADBEEF, response never high -> ack[0] on the 3rd edge after grant, rdata=0xDEADBEEF, err=0.
- Read miss: response high for 5 cycles, then cache_out=0x12345678 -> ack[0] exactly 5 cycles later than the hit case; rdata=0x12345678.
- All four req high continuously with pointer=0 -> acks in order 0,1,2,3,0. After a DONE for requester 2, the next grant goes to 3.
- Write: req[2], mode=1, data=0xA5A5A5A5, addr=0x40 -> cache_data=0xA5A5A5A5, cache_address=0x40, cache_mode=1 stable through DONE; rdata unchanged.
- Timeout: response stuck high -> ack with err=1 after TIMEOUT=255 WAIT cycles. The next transaction proceeds once response is 0.
